cdc_2phase_rx: RTL and testbench
================================

Name: cdc_2phase_rx

Overview:
- Receive-side endpoint of the team's 2-phase (toggle) req/ack handshake. It runs entirely in the destination clock domain.
- It synchronizes an asynchronous req toggle and captures the sender-held data word into a 2-entry output buffer. It then returns a registered ack toggle and presents the words on a valid/ready stream.
- The 2-entry buffer lets ack return before the consumer accepts, so one word can be in flight while one waits at the output.
- Sits at the clock boundary in front of USB endpoint/FIFO logic, pairing with a remote sender that toggles req and holds data until ack matches.

Parameters:
- DATA_WID, 8, width of the transferred data word.
- SYNC_STAGES, 2, number of flip-flops in the req synchronizer; must be >= 2 (elaboration error otherwise).

Ports:
- clk  input  1  destination-domain clock; all state on posedge.
- rst_n  input  1  asynchronous active-low reset; assertion clears all state immediately, release is synchronous to clk.
- req_i  input  1  asynchronous req toggle from sender; a level change means a new word is offered.
- data_i  input  DATA_WID  sender data; stable from the req_i toggle until ack_o equals req_i (quasi-static, not synchronized).
- ack_o  output  1  registered ack toggle back to the sender.
- valid_o  output  1  buffer head word available.
- ready_i  input  1  consumer accepts the head word when valid_o && ready_i.
- data_o  output  DATA_WID  buffer head word.
- level_o  output  2  buffer occupancy, 0..2.

Behaviour:
- Reset values:
  - Synchronizer flops 0; ack_o = 0; valid_o = 0; data_o = 0; level_o = 0.
  - Both buffer entries 0; read and write pointers 0.
- Synchronizer: req_i passes through SYNC_STAGES flops; the last stage is req_sync. No logic between stages.
- Pending condition:
  - pending = (req_sync != ack_o). This is a level compare, not edge detection, so a missed cycle cannot lose a request.
- Capture (push):
  - When pending && level < 2, at the next posedge:
    - data_i is written to buffer[wptr];
    - wptr flips;
    - ack_o toggles.
  - While level == 2, there is no capture and ack_o holds, so the sender stays blocked.
  - A pop in the same cycle does not enable a push at full: full is evaluated from the registered level only.
- Pop:
  - When valid_o && ready_i, rptr flips at the posedge.
  - ready_i while valid_o = 0 is ignored.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged (legal at level 1 only).
  - Level never exceeds 2 and never wraps below 0.
- Output decode:
  - valid_o = (level != 0).
  - data_o = buffer[rptr].
  - level_o = level.
  - All three decode from registers only; there is no combinational path from ready_i, req_i or data_i to any output.
- Latency:
  - A req_i toggle first sampled at posedge N gives req_sync at posedge N+SYNC_STAGES-1.
  - Capture, ack_o toggle and valid_o high all occur at posedge N+SYNC_STAGES.
  - ack_o therefore toggles SYNC_STAGES+1 posedges after the toggle, counting the sampling edge (3 edges for the default).
- Throughput: at most one capture per cycle, in practice bounded by the sender's round-trip.
- Stall: the ordering of words in the buffer is preserved (FIFO order) across any back-pressure pattern.
- Reset mid-operation:
  - The buffer contents are discarded and ack_o returns to 0.
  - The sender must be reset concurrently so that req = 0; otherwise a stale pending request is re-captured after reset.
- Protocol violation: a second req_i toggle before ack_o returns is undefined, and the block takes no corrective action.

Test Plan:
- Single word, SYNC_STAGES=2: after reset, set data_i=8'hA5 and toggle req_i 0->1 before posedge 0, with ready_i=0 -> ack_o=1, valid_o=1, data_o=8'hA5, level_o=1, all at posedge 2 (3rd edge, i.e. SYNC_STAGES+1), and these values hold.
- Fill and back-pressure: with ready_i=0, the sender sends 8'h11, 8'h22, 8'h33 -> level_o=2 and ack_o stops after the 2nd word; ack_o is unchanged while the 3rd is pending. Raise ready_i for 1 cycle -> pop 8'h11. The next posedge after level becomes 1 captures 8'h33 and ack_o toggles.
- Simultaneous push/pop at level 1: head 8'h11 with ready_i=1 while 8'h22 is captured -> level_o stays 1 and data_o=8'h22 next cycle.
- Streaming: ready_i=1 constant and 16 words 0..15 from a behavioural sender -> output sequence 0..15 in order with no duplicates and no drops.
- Reset mid-operation: level_o=2, assert rst_n low asynchronously between edges -> immediately valid_o=0, level_o=0, ack_o=0, data_o=0. After release, with sender req=0, nothing is captured.
- SYNC_STAGES=3 build: repeat the single-word test -> ack_o toggles at posedge 3 (4th edge).

Source files
------------

// File: rtl/cdc_2phase_rx.sv
// Receive endpoint of a 2-phase (toggle) req/ack crossing: synchronizes req,
// captures the sender-held word into a 2-entry buffer and streams it out.
module cdc_2phase_rx #(
  parameter int DATA_WID    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_i,
  input  logic [DATA_WID-1:0] data_i,
  output logic                ack_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [DATA_WID-1:0] data_o,
  output logic [1:0]          level_o
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("cdc_2phase_rx: SYNC_STAGES must be >= 2");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_sync;
  logic                   ack_q;
  logic                   wptr;
  logic                   rptr;
  logic [1:0]             level;
  logic [DATA_WID-1:0]    mem_q [2];
  logic                   pending;
  logic                   push;
  logic                   pop;

  assign req_sync = sync_q[SYNC_STAGES-1];

  // Level compare rather than edge detect: a request stays visible until acked.
  assign pending = (req_sync != ack_q);
  assign push    = pending && (level != 2'd2);

  // Stream handshake: a word moves on a posedge where valid_o && ready_i;
  // valid_o never depends on ready_i, and ready_i without valid_o is ignored.
  assign pop     = (level != 2'd0) && ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      ack_q    <= 1'b0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      level    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      if (push) begin
        mem_q[wptr] <= data_i;
        wptr        <= ~wptr;
        ack_q       <= ~ack_q;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign valid_o = (level != 2'd0);
  assign data_o  = mem_q[rptr];
  assign level_o = level;

endmodule

// File: tb/tb_cdc_2phase_rx.sv
// Directed bench for cdc_2phase_rx: queue-level reference model checked every
// cycle, an in-order scoreboard on the output stream, and literal spot checks.
module tb_cdc_2phase_rx;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_i = 1'b0;
  logic [W-1:0] data_i = '0;
  logic         ready_i = 1'b0;
  logic         ack_o;
  logic         valid_o;
  logic [W-1:0] data_o;
  logic [1:0]   level_o;

  logic         ack3_o;
  logic         valid3_o;
  logic [W-1:0] data3_o;
  logic [1:0]   level3_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  cdc_2phase_rx #(.DATA_WID(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .ack_o(ack_o),
    .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .level_o(level_o)
  );

  cdc_2phase_rx #(.DATA_WID(W), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .data_i(data_i), .ack_o(ack3_o),
    .valid_o(valid3_o), .ready_i(ready_i), .data_o(data3_o), .level_o(level3_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Buffer as a queue of words; req_sync seen at an edge is the req_i sample
  // taken S edges earlier.
  logic [W-1:0] m_q[$];
  logic         m_ack = 1'b0;
  logic         hist[$];
  logic         m_rs;
  logic         m_push;
  logic         m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      hist.delete();
      m_ack = 1'b0;
    end else begin
      m_rs   = (hist.size() >= S) ? hist[hist.size()-S] : 1'b0;
      m_pop  = (m_q.size() != 0) && ready_i;
      m_push = (m_rs != m_ack) && (m_q.size() < 2);
      if (m_pop) void'(m_q.pop_front());
      if (m_push) begin
        m_q.push_back(data_i);
        m_ack = ~m_ack;
      end
      hist.push_back(req_i);
      if (hist.size() > 8) void'(hist.pop_front());
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare + scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("model_ack", {31'd0, ack_o}, {31'd0, m_ack});
      check("model_level", {30'd0, level_o}, m_q.size());
      check("model_valid", {31'd0, valid_o}, {31'd0, m_q.size() != 0});
      if (m_q.size() != 0) check("model_data", {24'd0, data_o}, {24'd0, m_q[0]});
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) check("sb_extra_word", {24'd0, data_o}, 32'hFFFF_FFFF);
        else check("sb_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d);
    data_i = d;
    req_i  = ~req_i;
    exp_q.push_back(d);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ack_o == req_i) break;
    end
    check("send_ack_returned", {31'd0, ack_o}, {31'd0, req_i});
  endtask

  task automatic pop_cycles(input int n);
    ready_i = 1'b1;
    repeat (n) tick();
    ready_i = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_level", {30'd0, level_o}, 32'd0);
    check("rst_ack", {31'd0, ack_o}, 32'd0);
    check("rst_data", {24'd0, data_o}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Single word: toggle before edge 0, results at edge 2 (edge 3 for S=3)
    data_i = 8'hA5;
    req_i  = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    check("t1_e0_ack", {31'd0, ack_o}, 32'd0);
    check("t1_e0_valid", {31'd0, valid_o}, 32'd0);
    tick();
    check("t1_e1_ack", {31'd0, ack_o}, 32'd0);
    tick();
    check("t1_e2_ack", {31'd0, ack_o}, 32'd1);
    check("t1_e2_valid", {31'd0, valid_o}, 32'd1);
    check("t1_e2_data", {24'd0, data_o}, 32'hA5);
    check("t1_e2_level", {30'd0, level_o}, 32'd1);
    check("t1_s3_e2_ack", {31'd0, ack3_o}, 32'd0);
    tick();
    check("t1_s3_e3_ack", {31'd0, ack3_o}, 32'd1);
    check("t1_s3_e3_data", {24'd0, data3_o}, 32'hA5);
    check("t1_e3_hold_ack", {31'd0, ack_o}, 32'd1);
    check("t1_e3_hold_data", {24'd0, data_o}, 32'hA5);
    pop_cycles(1);
    check("t1_drained", {30'd0, level_o}, 32'd0);

    // Fill and back-pressure
    send_word(8'h11);
    send_word(8'h22);
    check("t2_full_level", {30'd0, level_o}, 32'd2);
    data_i = 8'h33;
    req_i  = ~req_i;
    exp_q.push_back(8'h33);
    repeat (6) tick();
    check("t2_blocked_ack", {31'd0, ack_o}, 32'd1);
    check("t2_blocked_level", {30'd0, level_o}, 32'd2);
    check("t2_blocked_head", {24'd0, data_o}, 32'h11);
    pop_cycles(1);
    check("t2_pop_level", {30'd0, level_o}, 32'd1);
    check("t2_pop_head", {24'd0, data_o}, 32'h22);
    check("t2_pop_ack_held", {31'd0, ack_o}, 32'd1);
    tick();
    check("t2_refill_level", {30'd0, level_o}, 32'd2);
    check("t2_refill_ack", {31'd0, ack_o}, 32'd0);
    pop_cycles(2);
    check("t2_drained", {30'd0, level_o}, 32'd0);

    // Simultaneous push and pop at level 1
    send_word(8'h11);
    check("t3_level1", {30'd0, level_o}, 32'd1);
    data_i = 8'h22;
    req_i  = ~req_i;
    exp_q.push_back(8'h22);
    tick();
    tick();
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("t3_pp_level", {30'd0, level_o}, 32'd1);
    check("t3_pp_data", {24'd0, data_o}, 32'h22);
    check("t3_pp_ack", {31'd0, ack_o}, 32'd0);
    pop_cycles(1);

    // Streaming with ready held high
    ready_i = 1'b1;
    for (int i = 0; i < 16; i++) send_word(W'(i));
    repeat (4) tick();
    ready_i = 1'b0;
    check("t4_all_delivered", exp_q.size(), 32'd0);
    check("t4_level", {30'd0, level_o}, 32'd0);

    // Asynchronous reset mid-operation with the buffer full
    send_word(8'h5A);
    send_word(8'hC3);
    check("t5_full", {30'd0, level_o}, 32'd2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'd0, valid_o}, 32'd0);
    check("t5_rst_level", {30'd0, level_o}, 32'd0);
    check("t5_rst_ack", {31'd0, ack_o}, 32'd0);
    check("t5_rst_data", {24'd0, data_o}, 32'd0);
    req_i = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("t5_post_level", {30'd0, level_o}, 32'd0);
    check("t5_post_ack", {31'd0, ack_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
